slice_sum_acc: RTL and testbench
================================

SLICE_SUM_ACC -- requirements
Module: slice_sum_acc

Interface
REQ-001 The block SHALL have parameter NSAMPLES, default 4, the number of input samples summed per frame (legal range 2..255).
REQ-002 The block SHALL have parameter SUM_WIDTH, default 8, the width of the signed result.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RST_N, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port CLR, input, 1 bit: synchronous abort of the current frame.
REQ-006 The block SHALL have port DIN, input, sint(4): the signed slice-sum sample from the upstream slice stage.
REQ-007 The block SHALL have port DIN_VALID, input, 1 bit: DIN is valid.
REQ-008 The block SHALL have port DIN_READY, output, 1 bit: the block accepts DIN this cycle.
REQ-009 The block SHALL have port SUM, output, sint(SUM_WIDTH): the frame result.
REQ-010 The block SHALL have port SUM_VALID, output, 1 bit: SUM is valid.
REQ-011 The block SHALL have port SUM_READY, input, 1 bit: the downstream stage takes SUM.
REQ-012 The block SHALL have port OVF, output, 1 bit: the frame exceeded the signed SUM_WIDTH range; valid while SUM_VALID is high.

Function
REQ-013 The block SHALL implement a two-state FSM, ACCUM and HOLD, and SHALL enter ACCUM on reset.
REQ-014 DIN_READY SHALL be high in ACCUM and low in HOLD, decoded from state only with no combinational path from inputs.
REQ-015 A sample SHALL be accepted on a cycle with DIN_VALID=1 and DIN_READY=1; DIN SHALL be sign-extended to SUM_WIDTH+1 bits before being added to the accumulator.
REQ-016 The sample counter SHALL increment per accepted sample; on the NSAMPLES-th accept the final sum SHALL be registered into SUM, SUM_VALID SHALL rise on the next cycle, the counter SHALL reset to 0 and the FSM SHALL go to HOLD (latency: 1 cycle after the last accept).
REQ-017 In HOLD, SUM, SUM_VALID and OVF SHALL stay stable until SUM_READY=1; on that cycle the FSM SHALL return to ACCUM, and SUM_VALID, the accumulator and OVF SHALL be 0 from the next cycle.
REQ-018 OVF SHALL be sticky within a frame and SHALL be set when any intermediate or final sum leaves [-2^(SUM_WIDTH-1), 2^(SUM_WIDTH-1)-1].
REQ-019 CLR=1 SHALL clear the accumulator, counter, OVF and SUM_VALID and force ACCUM on the next edge; CLR SHALL take priority over a simultaneous accept or SUM_READY, and the sample presented that cycle SHALL be discarded.
REQ-020 DIN_VALID while in HOLD SHALL be ignored and the sample SHALL NOT be lost upstream, because DIN_READY is low.
REQ-021 SUM_READY while in ACCUM SHALL have no effect.

Reset
REQ-022 With RST_N=0, the block SHALL asynchronously force: state ACCUM, counter 0, accumulator 0, SUM 0, SUM_VALID 0, OVF 0; DIN_READY SHALL read 1.
REQ-023 On release of RST_N, the block SHALL accept samples from the first rising CLK edge, and a frame in progress at reset assertion SHALL be discarded.

Configuration
REQ-024 When macro SLICE_SUM_ACC_SAT_EN is defined, an out-of-range sum SHALL clamp to the signed limit (+2^(SUM_WIDTH-1)-1 or -2^(SUM_WIDTH-1)), and accumulation SHALL continue from the clamped value.
REQ-025 When SLICE_SUM_ACC_SAT_EN is undefined, sums SHALL wrap modulo 2^SUM_WIDTH; OVF SHALL behave identically in both builds.

Structure
REQ-026 The FSM state enum and the function sat_add(acc, din, width) SHALL live in shared package pyxhdl_acc.
REQ-027 Saturation/wrap SHALL be a sub-module, slice_sum_sat, that is purely combinational and is instantiated once; all other logic SHALL be in slice_sum_acc.

Verification
REQ-028 Bench case: NSAMPLES=4, DIN 7,7,7,7 with DIN_VALID=1 and SUM_READY=1 -> SUM=28 and SUM_VALID high one cycle after the 4th accept, OVF=0.
REQ-029 Bench case: NSAMPLES=4, DIN -8 x4 -> SUM=-32; hold SUM_READY=0 for 5 cycles -> SUM stable and DIN_READY=0 throughout.
REQ-030 Bench case: NSAMPLES=40, DIN 7 x40 -> SUM=127 with OVF=1 (SAT_EN defined), or SUM=24 with OVF=1 (SAT_EN undefined).
REQ-031 Bench case: accept 2 samples of 5, then assert CLR together with DIN_VALID=1, then send 4 samples of 1 -> SUM=4.
REQ-032 Bench case: assert RST_N=0 mid-frame after 3 samples of 3 -> all outputs 0 immediately without a clock edge; next frame of 2,2,2,2 -> SUM=8.
REQ-033 Bench case: DIN_VALID toggling 1,0,1,0 with DIN 1,-1 alternating over 8 cycles -> SUM=0 after the 4th accept.

Source files
------------

// File: rtl/slice_sum_acc_pkg.sv
// Shared definitions for the slice-sum accumulator: FSM state encoding,
// fixed widths and the clamping adder used by the saturating build.
package pyxhdl_acc;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_e;

  // Width of the signed sample delivered by the upstream slice stage.
  localparam int DIN_W = 4;
  // Sample counter width; covers NSAMPLES up to 255.
  localparam int CNT_W = 8;

  // Signed add of acc and din, clamped to the signed range of 'width' bits.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] acc,
                                                 input logic signed [31:0] din,
                                                 input int width);
    logic signed [31:0] s;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    s  = acc + din;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (width - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/slice_sum_acc_sat.sv
// Combinational next-sum stage: adds one sign-extended sample to the
// accumulator and flags leaving the signed SUM_WIDTH range.
// Build option SLICE_SUM_ACC_SAT_EN: clamp to the signed limits instead of
// wrapping modulo 2^SUM_WIDTH. The overflow flag is the same in both builds.
module slice_sum_sat
  import pyxhdl_acc::*;
#(
  parameter int SUM_WIDTH = 8
) (
  input  logic signed [SUM_WIDTH-1:0] acc_i,
  input  logic signed [DIN_W-1:0]     din_i,
  output logic signed [SUM_WIDTH-1:0] sum_o,
  output logic                        ovf_o
);

  // One guard bit is enough: |acc| + |din| never exceeds SUM_WIDTH+1 bits.
  logic signed [SUM_WIDTH:0] sum_ext;

  assign sum_ext = {acc_i[SUM_WIDTH-1], acc_i}
                 + {{(SUM_WIDTH + 1 - DIN_W){din_i[DIN_W-1]}}, din_i};

  // Out of range exactly when the guard bit disagrees with the sign bit.
  assign ovf_o = sum_ext[SUM_WIDTH] ^ sum_ext[SUM_WIDTH-1];

`ifdef SLICE_SUM_ACC_SAT_EN
  assign sum_o = SUM_WIDTH'(sat_add(32'(acc_i), 32'(din_i), SUM_WIDTH));
`else
  assign sum_o = sum_ext[SUM_WIDTH-1:0];
`endif

endmodule

// File: rtl/slice_sum_acc.sv
// Frame accumulator: sums NSAMPLES signed 4-bit samples, presents the result
// with a valid/ready handshake and holds it until taken downstream.
// Build option SLICE_SUM_ACC_SAT_EN selects saturating instead of wrapping sums.
module slice_sum_acc
  import pyxhdl_acc::*;
#(
  parameter int NSAMPLES  = 4,
  parameter int SUM_WIDTH = 8
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        CLR,
  input  logic signed [DIN_W-1:0]     DIN,
  input  logic                        DIN_VALID,
  output logic                        DIN_READY,
  output logic signed [SUM_WIDTH-1:0] SUM,
  output logic                        SUM_VALID,
  input  logic                        SUM_READY,
  output logic                        OVF
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSAMPLES - 1);

  acc_state_e                  state_q;
  logic [CNT_W-1:0]            cnt_q;
  logic signed [SUM_WIDTH-1:0] acc_q;
  logic signed [SUM_WIDTH-1:0] sum_q;
  logic                        sum_valid_q;
  logic                        ovf_q;

  logic signed [SUM_WIDTH-1:0] acc_d;
  logic                        step_ovf;
  logic                        accept;

  // Ready is decoded from state alone so no input reaches it combinationally.
  assign DIN_READY = (state_q == ACCUM);
  assign accept    = DIN_VALID & DIN_READY;

  slice_sum_sat #(
    .SUM_WIDTH(SUM_WIDTH)
  ) u_sat (
    .acc_i(acc_q),
    .din_i(DIN),
    .sum_o(acc_d),
    .ovf_o(step_ovf)
  );

  // Frame FSM with registered result, valid and sticky overflow; CLR wins over everything.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (CLR) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      acc_q       <= '0;
      sum_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            acc_q <= acc_d;
            ovf_q <= ovf_q | step_ovf;
            if (cnt_q == LAST_CNT) begin
              sum_q       <= acc_d;
              sum_valid_q <= 1'b1;
              cnt_q       <= '0;
              state_q     <= HOLD;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (SUM_READY) begin
            state_q     <= ACCUM;
            sum_valid_q <= 1'b0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign SUM       = sum_q;
  assign SUM_VALID = sum_valid_q;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_slice_sum_acc.sv
// Directed bench for slice_sum_acc: one 4-sample and one 40-sample instance,
// hand-computed expected values for both the wrapping and saturating builds.
module tb_slice_sum_acc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic              clr4 = 1'b0, dv4 = 1'b0, sr4 = 1'b1;
  logic signed [3:0] din4 = '0;
  logic              drdy4, sv4, ovf4;
  logic signed [7:0] sum4;

  logic              clr40 = 1'b0, dv40 = 1'b0, sr40 = 1'b1;
  logic signed [3:0] din40 = '0;
  logic              drdy40, sv40, ovf40;
  logic signed [7:0] sum40;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  slice_sum_acc #(.NSAMPLES(4), .SUM_WIDTH(8)) u_dut4 (
    .CLK(clk), .RST_N(rst_n), .CLR(clr4), .DIN(din4), .DIN_VALID(dv4),
    .DIN_READY(drdy4), .SUM(sum4), .SUM_VALID(sv4), .SUM_READY(sr4), .OVF(ovf4)
  );

  slice_sum_acc #(.NSAMPLES(40), .SUM_WIDTH(8)) u_dut40 (
    .CLK(clk), .RST_N(rst_n), .CLR(clr40), .DIN(din40), .DIN_VALID(dv40),
    .DIN_READY(drdy40), .SUM(sum40), .SUM_VALID(sv40), .SUM_READY(sr40), .OVF(ovf40)
  );

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_ready", 32'(drdy4), 1);
    chk("rst_valid", 32'(sv4), 0);
    chk("rst_sum", 32'(sum4), 0);
    chk("rst_ovf", 32'(ovf4), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 7 x4 -> 28, valid right after the 4th accept
    din4 = 4'sd7; dv4 = 1'b1; sr4 = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("c1_valid_early", 32'(sv4), 0);
    tick();
    chk("c1_valid", 32'(sv4), 1);
    chk("c1_sum", 32'(sum4), 28);
    chk("c1_ovf", 32'(ovf4), 0);
    dv4 = 1'b0;
    tick();
    chk("c1_valid_drop", 32'(sv4), 0);
    chk("c1_ready_back", 32'(drdy4), 1);

    // -8 x4 -> -32, held while SUM_READY low, DIN_VALID kept high in HOLD
    sr4 = 1'b0; din4 = 4'(-8); dv4 = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("c2_sum", 32'(sum4), -32);
    chk("c2_valid", 32'(sv4), 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("c2_hold_sum", 32'(sum4), -32);
      chk("c2_hold_ready", 32'(drdy4), 0);
      chk("c2_hold_valid", 32'(sv4), 1);
    end
    sr4 = 1'b1; dv4 = 1'b0;
    tick();
    chk("c2_release_valid", 32'(sv4), 0);
    chk("c2_release_ready", 32'(drdy4), 1);

    // 7 x40 on the long-frame instance; overflow first appears at 19*7=133
    din40 = 4'sd7; dv40 = 1'b1; sr40 = 1'b1;
    for (int i = 0; i < 18; i++) tick();
    chk("c3_ovf_18", 32'(ovf40), 0);
    tick();
    chk("c3_ovf_19", 32'(ovf40), 1);
    for (int i = 19; i < 40; i++) tick();
    chk("c3_valid", 32'(sv40), 1);
`ifdef SLICE_SUM_ACC_SAT_EN
    chk("c3_sum", 32'(sum40), 127);
`else
    chk("c3_sum", 32'(sum40), 24);
`endif
    chk("c3_ovf", 32'(ovf40), 1);
    dv40 = 1'b0;
    tick();
    chk("c3_ovf_clear", 32'(ovf40), 0);
    chk("c3_valid_drop", 32'(sv40), 0);

    // 5,5 then CLR with a valid sample (discarded), then 1 x4 -> 4
    din4 = 4'sd5; dv4 = 1'b1;
    tick(); tick();
    clr4 = 1'b1;
    tick();
    clr4 = 1'b0;
    chk("c4_clr_ready", 32'(drdy4), 1);
    chk("c4_clr_valid", 32'(sv4), 0);
    din4 = 4'sd1;
    for (int i = 0; i < 4; i++) tick();
    chk("c4_sum", 32'(sum4), 4);
    chk("c4_valid", 32'(sv4), 1);
    dv4 = 1'b0;
    tick();

    // 3 x3 then asynchronous reset mid-frame; outputs clear with no edge
    din4 = 4'sd3; dv4 = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    dv4 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("c5_rst_sum", 32'(sum4), 0);
    chk("c5_rst_valid", 32'(sv4), 0);
    chk("c5_rst_ovf", 32'(ovf4), 0);
    chk("c5_rst_ready", 32'(drdy4), 1);
    @(negedge clk);
    rst_n = 1'b1;
    din4 = 4'sd2; dv4 = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("c5_sum", 32'(sum4), 8);
    chk("c5_valid", 32'(sv4), 1);
    dv4 = 1'b0;
    tick();

    // Valid toggling 1,0,...; accepted samples 1,-1,1,-1; idle cycles carry junk
    sr4 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        dv4  = 1'b1;
        din4 = ((i / 2) % 2 == 0) ? 4'sd1 : 4'(-1);
      end else begin
        dv4  = 1'b0;
        din4 = 4'sd7;
      end
      tick();
      if (i == 5) chk("c6_valid_early", 32'(sv4), 0);
    end
    chk("c6_sum", 32'(sum4), 0);
    chk("c6_valid", 32'(sv4), 1);
    chk("c6_ovf", 32'(ovf4), 0);
    sr4 = 1'b1;
    tick();
    chk("c6_release", 32'(sv4), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
